// File: rtl/ppu_vram_pkg.sv
// Shared types and default widths for the PPU/CPU VRAM arbiter and the PPU character fetcher.
package ppu_vram_pkg;

  localparam int VRAM_ADDR_W = 12;
  localparam int VRAM_DATA_W = 8;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_wr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_PEND  = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DATA  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Posted CPU write FIFO; head entry visible combinationally, 1-cycle push-to-pop.
// Push is refused when full unless a pop happens in the same cycle.
module vram_wr_fifo
  import ppu_vram_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = vram_wr_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_dat,
  input  logic   pop,
  output entry_t head_dat,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// VRAM arbiter: PPU fetch has absolute priority and 2-cycle latency; CPU writes posted, reads ordered behind them.
// CPU is held off by withholding cpu_ack. Define ARB_STATS_EN to add stall_cnt/stall_last.
module ppu_vram_arbiter
  import ppu_vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_valid,
  output logic [DATA_W-1:0] ppu_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       stall_last
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ent_t;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ppu_pend_q, ppu_pend_d;
  logic              ppu_valid_q, ppu_valid_d;
  logic [DATA_W-1:0] ppu_data_q, ppu_data_d;

  logic    wr_push, wr_pop, fifo_full, fifo_empty, gnt_rd, cpu_take;
  wr_ent_t push_ent, head_ent;

  assign push_ent = '{addr: cpu_addr, data: cpu_wdata};

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(wr_ent_t)) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_push),
    .push_dat(push_ent),
    .pop     (wr_pop),
    .head_dat(head_ent),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    // A read only wins once every older posted write has drained.
    gnt_rd   = !ppu_req && (state_q == RD_PEND) && fifo_empty;
    wr_pop   = !ppu_req && !fifo_empty;
    cpu_take = (state_q == IDLE) && cpu_req && !cpu_ack_q;
    wr_push  = cpu_take && cpu_we && !fifo_full;

    mem_en_d    = ppu_req || gnt_rd || wr_pop;
    mem_we_d    = wr_pop;
    mem_addr_d  = ppu_req ? ppu_addr : gnt_rd ? rd_addr_q : wr_pop ? head_ent.addr : '0;
    mem_wdata_d = wr_pop ? head_ent.data : '0;

    ppu_pend_d  = ppu_req;
    ppu_valid_d = ppu_pend_q;
    ppu_data_d  = ppu_pend_q ? mem_rdata : ppu_data_q;

    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = wr_push;
    case (state_q)
      IDLE: begin
        if (cpu_take && !cpu_we) begin
          state_d   = RD_PEND;
          rd_addr_d = cpu_addr;
        end
      end
      RD_PEND:  if (gnt_rd) state_d = RD_ISSUE;
      RD_ISSUE: begin
        state_d     = RD_DATA;
        cpu_rdata_d = mem_rdata;
        cpu_ack_d   = 1'b1;
      end
      RD_DATA:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ppu_pend_q  <= 1'b0;
      ppu_valid_q <= 1'b0;
      ppu_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ppu_pend_q  <= ppu_pend_d;
      ppu_valid_q <= ppu_valid_d;
      ppu_data_q  <= ppu_data_d;
    end
  end

  assign ppu_valid = ppu_valid_q;
  assign ppu_data  = ppu_data_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_busy  = !fifo_empty || (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, stall_last_q, stall_last_d;
  logic        stall;

  always_comb begin
    stall        = ppu_req && (!fifo_empty || (state_q == RD_PEND));
    stall_cnt_d  = stall_cnt_q;
    stall_last_d = stall_last_q;
    if (frame) begin
      stall_last_d = stall_cnt_q;
      stall_cnt_d  = '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      stall_last_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      stall_last_q <= stall_last_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign stall_last = stall_last_q;
`else
  logic unused_frame;
  assign unused_frame = frame;
`endif

endmodule
